// File: rtl/multicycle_controller_pkg.sv
// Shared ALU encodings, RV32 opcodes and state/format types for the
// multi-cycle controller and its instruction decoder.
package controller_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK, ST_TRAP
    } state_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_IMM, FMT_LOAD, FMT_STORE, FMT_BRANCH, FMT_NONE
    } fmt_e;

    // alt selects sub/sra over add/srl (func7 bit 5).
    function automatic logic [3:0] arith_op(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_controller_instr_decoder.sv
// Combinational RV32 decode: legality, format class, ALU operation and the
// static operand / write-back select outputs.
module instr_decoder
    import controller_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH  = 32,
    parameter int unsigned ALU_OP_WIDTH = 4
) (
    input  logic [INSTR_WIDTH-1:0]  instruction,
    output logic                    legal,
    output fmt_e                    fmt,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    sel_bw_imm_rs2,
    output logic                    wr_back_sel
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = instruction[6:0];
    assign funct3        = instruction[14:12];
    assign funct7        = instruction[31:25];
    assign unused_fields = ^{instruction[24:15], instruction[11:7]};

    always_comb begin
        legal          = 1'b0;
        fmt            = FMT_NONE;
        alu_op         = ALU_OP_WIDTH'(ALU_ADD);
        sel_bw_imm_rs2 = 1'b1;
        wr_back_sel    = 1'b1;
        case (opcode)
            OP_R: begin
                fmt    = FMT_R;
                legal  = (funct7 == 7'h00) ||
                         (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
                alu_op = ALU_OP_WIDTH'(arith_op(funct3, funct7[5]));
            end
            OP_IMM: begin
                fmt            = FMT_IMM;
                sel_bw_imm_rs2 = 1'b0;
                case (funct3)
                    3'd1:    legal = (funct7 == 7'h00);
                    3'd5:    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                    default: legal = 1'b1;
                endcase
                // Only the shift-right immediate uses func7 to pick arithmetic.
                alu_op = ALU_OP_WIDTH'(arith_op(funct3, (funct3 == 3'd5) && funct7[5]));
            end
            OP_LOAD: begin
                fmt            = FMT_LOAD;
                sel_bw_imm_rs2 = 1'b0;
                wr_back_sel    = 1'b0;
                legal          = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            end
            OP_STORE: begin
                fmt            = FMT_STORE;
                sel_bw_imm_rs2 = 1'b0;
                legal          = (funct3 <= 3'd2);
            end
            OP_BRANCH: begin
                fmt    = FMT_BRANCH;
                alu_op = ALU_OP_WIDTH'(ALU_SUB);
                legal  = (funct3 != 3'd2) && (funct3 != 3'd3);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32 control FSM: fetch/decode/execute/mem/writeback sequencing,
// dmem timeout and illegal-instruction traps, and the retired-instruction count.
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH  = 32,
    parameter int unsigned ALU_OP_WIDTH = 4,
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INSTR_WIDTH-1:0]  instruction,
    input  logic                    imem_valid,
    input  logic                    dmem_ready,
    input  logic                    branch_taken,
    output logic                    imem_req,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    pc_sel,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    sel_bw_imm_rs2,
    output logic                    regfile_write_enable,
    output logic                    dmem_read_en,
    output logic                    dmem_write_en,
    output logic                    wr_back_sel,
    output logic                    illegal_instr,
    output logic                    mem_fault,
    output logic [CNT_WIDTH-1:0]    instret
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e                    state_q, state_d;
    logic [WAIT_W-1:0]         wait_q, wait_d;
    logic                      illegal_q, illegal_d;
    logic                      fault_q, fault_d;
    logic [CNT_WIDTH-1:0]      instret_q, instret_d;

    logic                      dec_legal;
    fmt_e                      dec_fmt;
    logic [ALU_OP_WIDTH-1:0]   dec_alu_op;

    instr_decoder #(
        .INSTR_WIDTH  (INSTR_WIDTH),
        .ALU_OP_WIDTH (ALU_OP_WIDTH)
    ) u_decoder (
        .instruction    (instruction),
        .legal          (dec_legal),
        .fmt            (dec_fmt),
        .alu_op         (dec_alu_op),
        .sel_bw_imm_rs2 (sel_bw_imm_rs2),
        .wr_back_sel    (wr_back_sel)
    );

    always_comb begin
        state_d              = state_q;
        wait_d               = wait_q;
        illegal_d            = illegal_q;
        fault_d              = fault_q;
        instret_d            = instret_q;
        imem_req             = 1'b0;
        ir_write             = 1'b0;
        pc_write             = 1'b0;
        pc_sel               = 1'b0;
        alu_op               = ALU_OP_WIDTH'(ALU_ADD);
        regfile_write_enable = 1'b0;
        dmem_read_en         = 1'b0;
        dmem_write_en        = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = rst_n;
                ir_write = rst_n && imem_valid;
                if (imem_valid) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (!dec_legal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                alu_op = dec_alu_op;
                wait_d = '0;
                case (dec_fmt)
                    FMT_LOAD, FMT_STORE: state_d = ST_MEM;
                    FMT_BRANCH: begin
                        pc_write  = 1'b1;
                        pc_sel    = branch_taken;
                        instret_d = instret_q + CNT_WIDTH'(1);
                        state_d   = ST_FETCH;
                    end
                    default: state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEM: begin
                dmem_read_en  = (dec_fmt == FMT_LOAD);
                dmem_write_en = (dec_fmt == FMT_STORE);
                // Ready is tested before the timeout so a late ready still completes.
                if (dmem_ready) begin
                    if (dec_fmt == FMT_LOAD) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        pc_write  = 1'b1;
                        instret_d = instret_q + CNT_WIDTH'(1);
                        state_d   = ST_FETCH;
                    end
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = ST_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_WRITEBACK: begin
                regfile_write_enable = 1'b1;
                pc_write             = 1'b1;
                instret_d            = instret_q + CNT_WIDTH'(1);
                state_d              = ST_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
            instret_q <= instret_d;
        end
    end

    assign illegal_instr = illegal_q;
    assign mem_fault     = fault_q;
    assign instret       = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction timeline model derived from the cycle
// rules of each instruction class, compared against the controller every cycle.
module tb_multicycle_controller;

    localparam int unsigned TMO = 16;
    localparam int unsigned CW  = 4;

    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_ILL = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   instruction = '0;
    logic          imem_valid = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          branch_taken = 1'b0;
    logic          imem_req, ir_write, pc_write, pc_sel;
    logic [3:0]    alu_op;
    logic          sel_bw_imm_rs2, regfile_write_enable, dmem_read_en, dmem_write_en;
    logic          wr_back_sel, illegal_instr, mem_fault;
    logic [CW-1:0] instret;

    multicycle_controller #(
        .INSTR_WIDTH  (32),
        .ALU_OP_WIDTH (4),
        .MEM_TIMEOUT  (TMO),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .instruction          (instruction),
        .imem_valid           (imem_valid),
        .dmem_ready           (dmem_ready),
        .branch_taken         (branch_taken),
        .imem_req             (imem_req),
        .ir_write             (ir_write),
        .pc_write             (pc_write),
        .pc_sel               (pc_sel),
        .alu_op               (alu_op),
        .sel_bw_imm_rs2       (sel_bw_imm_rs2),
        .regfile_write_enable (regfile_write_enable),
        .dmem_read_en         (dmem_read_en),
        .dmem_write_en        (dmem_write_en),
        .wr_back_sel          (wr_back_sel),
        .illegal_instr        (illegal_instr),
        .mem_fault            (mem_fault),
        .instret              (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req, ir_write, pc_write, pc_sel;
        logic [3:0] alu_op;
        logic       sel, rf_we, rd, wr, wbs, ill, flt;
        logic [3:0] instret;
    } exp_t;

    int   n_chk = 0, n_pass = 0;
    int   mode = 0;
    exp_t ex;
    int   cur_cyc = 0, rd_cnt = 0, wr_cnt = 0, rfwe_cyc = 0, pcsel_cyc = 0;
    int   m_ret = 0;
    logic m_ill = 1'b0, m_flt = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cur_cyc, act, req);
    endtask

    function automatic int cls_of(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'h33: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? C_R : C_ILL;
            7'h13: begin
                if (f3 == 3'd1 && f7 != 7'h00) return C_ILL;
                if (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)) return C_ILL;
                return C_I;
            end
            7'h03: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? C_LD : C_ILL;
            7'h23: return (f3 inside {3'd0, 3'd1, 3'd2}) ? C_ST : C_ILL;
            7'h63: return (f3 inside {3'd2, 3'd3}) ? C_ILL : C_BR;
            default: return C_ILL;
        endcase
    endfunction

    // add,sll,slt,sltu,xor,srl,or,and by func3; sub/sra sit one code above add/srl.
    function automatic logic [3:0] model_alu(input logic [31:0] ins);
        int  base [8];
        int  c;
        logic alt;
        base = '{0, 2, 3, 4, 5, 6, 8, 9};
        c    = cls_of(ins);
        alt  = (ins[31:25] == 7'h20);
        case (c)
            C_R:     return 4'(base[ins[14:12]] + (alt ? 1 : 0));
            C_I:     return 4'(base[ins[14:12]] + ((alt && ins[14:12] == 3'd5) ? 1 : 0));
            C_BR:    return 4'd1;
            default: return 4'd0;
        endcase
    endfunction

    function automatic exp_t mk(input logic [31:0] ins);
        exp_t e;
        e         = '0;
        e.sel     = !(ins[6:0] == 7'h13 || ins[6:0] == 7'h03 || ins[6:0] == 7'h23);
        e.wbs     = (ins[6:0] != 7'h03);
        e.ill     = m_ill;
        e.flt     = m_flt;
        e.instret = 4'(m_ret % (1 << CW));
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 9))
            0, 1:    ins[6:0] = 7'h33;
            2, 3:    ins[6:0] = 7'h13;
            4, 5:    ins[6:0] = 7'h03;
            6:       ins[6:0] = 7'h23;
            7, 8:    ins[6:0] = 7'h63;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0, 1:    ins[31:25] = 7'h00;
            2:       ins[31:25] = 7'h20;
            default: ;
        endcase
        return ins;
    endfunction

    task automatic drive(input logic iv, input logic dr, input logic bt, input exp_t e);
        imem_valid   = iv;
        dmem_ready   = dr;
        branch_taken = bt;
        ex           = e;
        mode         = 1;
        cur_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        imem_valid   = rb();
        dmem_ready   = 1'b0;
        branch_taken = rb();
        mode         = 2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ret = 0;
        m_ill = 1'b0;
        m_flt = 1'b0;
        mode  = 0;
    endtask

    task automatic trap_cycles(input logic [31:0] ins);
        for (int i = 0; i < 3; i++) drive(rb(), rb(), rb(), mk(ins));
    endtask

    task automatic run_instr(input logic [31:0] ins, input int idly, input int dwait,
                             input logic bt, input int abort_at, output logic trapped);
        exp_t       e;
        int         c;
        logic [3:0] a;
        c           = cls_of(ins);
        a           = model_alu(ins);
        trapped     = 1'b0;
        instruction = ins;
        cur_cyc     = 0;
        rd_cnt      = 0;
        wr_cnt      = 0;
        rfwe_cyc    = 0;
        pcsel_cyc   = 0;
        for (int i = 0; i < idly; i++) begin
            e = mk(ins); e.imem_req = 1'b1;
            drive(1'b0, 1'b0, rb(), e);
        end
        e = mk(ins); e.imem_req = 1'b1; e.ir_write = 1'b1;
        drive(1'b1, 1'b0, rb(), e);
        drive(rb(), 1'b0, rb(), mk(ins));
        if (c == C_ILL) begin
            m_ill = 1'b1;
            trap_cycles(ins);
            trapped = 1'b1;
            return;
        end
        e = mk(ins); e.alu_op = a;
        if (c == C_BR) begin
            e.pc_write = 1'b1; e.pc_sel = bt;
            drive(rb(), 1'b0, bt, e);
            m_ret++;
            return;
        end
        drive(rb(), 1'b0, rb(), e);
        if (c == C_LD || c == C_ST) begin
            for (int w = 0; w < int'(TMO); w++) begin
                if (w == abort_at) begin
                    do_reset();
                    return;
                end
                e = mk(ins); e.rd = (c == C_LD); e.wr = (c == C_ST);
                if (w == dwait) begin
                    if (c == C_ST) begin
                        e.pc_write = 1'b1;
                        drive(rb(), 1'b1, rb(), e);
                        m_ret++;
                        return;
                    end
                    drive(rb(), 1'b1, rb(), e);
                    break;
                end
                drive(rb(), 1'b0, rb(), e);
                if (w == int'(TMO) - 1) begin
                    m_flt = 1'b1;
                    trap_cycles(ins);
                    trapped = 1'b1;
                    return;
                end
            end
        end
        e = mk(ins); e.rf_we = 1'b1; e.pc_write = 1'b1;
        drive(rb(), 1'b0, rb(), e);
        m_ret++;
    endtask

    always @(negedge clk) begin
        if (mode == 2) begin
            chk("rst_imem_req", 32'(imem_req), 0);
            chk("rst_ir_write", 32'(ir_write), 0);
        end else if (mode == 1) begin
            chk("imem_req", 32'(imem_req), 32'(ex.imem_req));
            chk("ir_write", 32'(ir_write), 32'(ex.ir_write));
            chk("pc_write", 32'(pc_write), 32'(ex.pc_write));
            chk("pc_sel", 32'(pc_sel), 32'(ex.pc_sel));
            chk("alu_op", 32'(alu_op), 32'(ex.alu_op));
            chk("sel_bw_imm_rs2", 32'(sel_bw_imm_rs2), 32'(ex.sel));
            chk("regfile_write_enable", 32'(regfile_write_enable), 32'(ex.rf_we));
            chk("dmem_read_en", 32'(dmem_read_en), 32'(ex.rd));
            chk("dmem_write_en", 32'(dmem_write_en), 32'(ex.wr));
            chk("wr_back_sel", 32'(wr_back_sel), 32'(ex.wbs));
            chk("illegal_instr", 32'(illegal_instr), 32'(ex.ill));
            chk("mem_fault", 32'(mem_fault), 32'(ex.flt));
            chk("instret", 32'(instret), 32'(ex.instret));
            if (dmem_read_en === 1'b1) rd_cnt++;
            if (dmem_write_en === 1'b1) wr_cnt++;
            if (regfile_write_enable === 1'b1) rfwe_cyc = cur_cyc;
            if (pc_sel === 1'b1) pcsel_cyc = cur_cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        t;
        logic [31:0] ins;
        int          dw;
        @(posedge clk);
        #1;
        do_reset();
        #1;
        chk("reset_instret", 32'(instret), 0);
        chk("reset_illegal", 32'(illegal_instr), 0);
        chk("reset_fault", 32'(mem_fault), 0);
        chk("reset_first_fetch", 32'(imem_req), 1);

        run_instr(32'h002081B3, 0, 0, 1'b0, -1, t);
        chk("add_wb_cycle", 32'(rfwe_cyc), 4);
        chk("add_instret", 32'(instret), 1);

        run_instr(32'h0000A183, 0, 2, 1'b0, -1, t);
        chk("lw_read_cycles", 32'(rd_cnt), 3);
        chk("lw_wb_cycle", 32'(rfwe_cyc), 7);
        chk("lw_instret", 32'(instret), 2);

        run_instr(32'h00208063, 0, 0, 1'b1, -1, t);
        chk("beq_pcsel_cycle", 32'(pcsel_cyc), 3);
        chk("beq_no_rf_write", 32'(rfwe_cyc), 0);
        chk("beq_instret", 32'(instret), 3);

        run_instr(32'h0020A023, 0, int'(TMO) - 1, 1'b0, -1, t);
        chk("sw_late_ready_writes", 32'(wr_cnt), 16);
        chk("sw_late_ready_no_fault", 32'(mem_fault), 0);
        chk("sw_late_ready_instret", 32'(instret), 4);

        run_instr(32'h0020A023, 2, int'(TMO) + 5, 1'b0, -1, t);
        chk("sw_timeout_writes", 32'(wr_cnt), 16);
        chk("sw_timeout_fault", 32'(mem_fault), 1);
        do_reset();

        run_instr(32'h4210D193, 0, 0, 1'b0, -1, t);
        chk("srai_bad_illegal", 32'(illegal_instr), 1);
        chk("srai_bad_no_pc_write", 32'(pc_write), 0);
        do_reset();

        run_instr(32'h00000013, 0, 0, 1'b0, -1, t);
        run_instr(32'h0000A183, 0, 10, 1'b0, 2, t);
        #1;
        chk("abort_read_dropped", 32'(dmem_read_en), 0);
        chk("abort_fetch", 32'(imem_req), 1);
        chk("abort_instret", 32'(instret), 0);

        for (int i = 0; i < 17; i++)
            run_instr((i % 2 == 0) ? 32'h002081B3 : 32'h00208063, i % 3, 0, rb(), -1, t);
        chk("wrap_instret", 32'(instret), 1);

        for (int i = 0; i < 300; i++) begin
            ins = gen();
            case ($urandom_range(0, 9))
                0:       dw = int'(TMO) - 1;
                1:       dw = int'(TMO);
                default: dw = $urandom_range(0, 4);
            endcase
            run_instr(ins, $urandom_range(0, 2), dw, rb(), -1, t);
            if (t) do_reset();
        end

        mode = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
